// File: rtl/sirius_fetch_pkg.sv
// Shared types and constants for the sirius instruction fetch queue.
// Holds the default queue depth, the {pc,inst} entry layout and the sequential PC step.
package sirius_fetch_pkg;

    localparam int FQ_DEPTH  = 8;
    localparam int FQ_PC_W   = 32;
    localparam int FQ_INST_W = 32;
    localparam int PC_STEP   = 4;

    typedef struct packed {
        logic [FQ_PC_W-1:0]   pc;
        logic [FQ_INST_W-1:0] inst;
    } fq_entry_t;

    // Decode can only take two per cycle, so a request of 3 is treated as 2.
    function automatic logic [1:0] fq_deq_req(input logic [1:0] deq_num);
        return (deq_num == 2'd3) ? 2'd2 : deq_num;
    endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Storage array for the fetch queue: two write ports, two asynchronous read ports.
// The array itself is not reset; validity is tracked by the pointer logic in the top.
module fetch_queue_ram
    import sirius_fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int WIDTH = $bits(fq_entry_t),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we_0,
    input  logic [AW-1:0]    i_waddr_0,
    input  logic [WIDTH-1:0] i_wdata_0,
    input  logic             i_we_1,
    input  logic [AW-1:0]    i_waddr_1,
    input  logic [WIDTH-1:0] i_wdata_1,
    input  logic [AW-1:0]    i_raddr_0,
    output logic [WIDTH-1:0] o_rdata_0,
    input  logic [AW-1:0]    i_raddr_1,
    output logic [WIDTH-1:0] o_rdata_1
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // The two write addresses are always tail and tail+1, so they never collide.
    always_ff @(posedge i_clk) begin
        if (i_we_0) r_mem[i_waddr_0] <= i_wdata_0;
        if (i_we_1) r_mem[i_waddr_1] <= i_wdata_1;
    end

    assign o_rdata_0 = r_mem[i_raddr_0];
    assign o_rdata_1 = r_mem[i_raddr_1];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode decoupling FIFO: up to two enqueues and two dequeues per cycle, flushable.
// Optional macro FETCH_QUEUE_PERF_EN adds saturating full/empty cycle counters.
module inst_fetch_queue
    import sirius_fetch_pkg::*;
#(
    parameter int DEPTH  = FQ_DEPTH,
    parameter int PC_W   = FQ_PC_W,
    parameter int INST_W = FQ_INST_W
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     flush,
    input  logic                     in_ok_1,
    input  logic                     in_ok_2,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_data_1,
    input  logic [INST_W-1:0]        in_data_2,
    output logic                     in_ready,
    output logic                     out_valid_1,
    output logic                     out_valid_2,
    output logic [PC_W-1:0]          out_pc_1,
    output logic [PC_W-1:0]          out_pc_2,
    output logic [INST_W-1:0]        out_inst_1,
    output logic [INST_W-1:0]        out_inst_2,
    input  logic [1:0]               deq_num,
    output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]              perf_full_cycles,
    output logic [31:0]              perf_empty_cycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = PC_W + INST_W;

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_ready;
    logic [1:0]       w_enq_n;
    logic [1:0]       w_deq_req;
    logic [1:0]       w_deq_eff;
    logic [PC_W-1:0]  w_pc_2;
    logic [ENT_W-1:0] w_rdata_0;
    logic [ENT_W-1:0] w_rdata_1;

    assign w_ready   = (r_count <= CNT_W'(DEPTH - 2));
    assign w_deq_req = fq_deq_req(deq_num);
    assign w_pc_2    = in_pc + PC_W'(PC_STEP);

    // Enqueues while not ready are dropped; flush cancels all same-cycle traffic.
    always_comb begin
        w_enq_n = 2'd0;
        if (!flush && in_ok_1 && w_ready)
            w_enq_n = in_ok_2 ? 2'd2 : 2'd1;
    end

    // Dequeue never reaches entries written this cycle: it is bounded by the registered count.
    always_comb begin
        w_deq_eff = 2'd0;
        if (!flush)
            w_deq_eff = (CNT_W'(w_deq_req) > r_count) ? r_count[1:0] : w_deq_req;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_deq_eff);
            r_tail  <= r_tail + PTR_W'(w_enq_n);
            r_count <= r_count + CNT_W'(w_enq_n) - CNT_W'(w_deq_eff);
        end
    end

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ram (
        .i_clk     (aclk),
        .i_we_0    (w_enq_n != 2'd0),
        .i_waddr_0 (r_tail),
        .i_wdata_0 ({in_pc, in_data_1}),
        .i_we_1    (w_enq_n == 2'd2),
        .i_waddr_1 (r_tail + PTR_W'(1)),
        .i_wdata_1 ({w_pc_2, in_data_2}),
        .i_raddr_0 (r_head),
        .o_rdata_0 (w_rdata_0),
        .i_raddr_1 (r_head + PTR_W'(1)),
        .o_rdata_1 (w_rdata_1)
    );

    assign in_ready    = w_ready;
    assign count       = r_count;
    assign out_valid_1 = (r_count != '0);
    assign out_valid_2 = (r_count >= CNT_W'(2));
    assign out_pc_1    = w_rdata_0[ENT_W-1:INST_W];
    assign out_inst_1  = w_rdata_0[INST_W-1:0];
    assign out_pc_2    = w_rdata_1[ENT_W-1:INST_W];
    assign out_inst_2  = w_rdata_1[INST_W-1:0];

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] r_perf_full;
    logic [31:0] r_perf_empty;

    // Observation only: these counters ignore flush and saturate rather than wrap.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_perf_full  <= '0;
            r_perf_empty <= '0;
        end else begin
            if (!w_ready && (r_perf_full != 32'hFFFF_FFFF))
                r_perf_full <= r_perf_full + 32'd1;
            if ((r_count == '0) && (r_perf_empty != 32'hFFFF_FFFF))
                r_perf_empty <= r_perf_empty + 32'd1;
        end
    end

    assign perf_full_cycles  = r_perf_full;
    assign perf_empty_cycles = r_perf_empty;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed vector table, random traffic
// against a queue-based reference model, and reset corner cases.
module tb_inst_fetch_queue;
    import sirius_fetch_pkg::*;

    localparam int DEPTH = 8;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        flush;
    logic        in_ok_1;
    logic        in_ok_2;
    logic [31:0] in_pc;
    logic [31:0] in_data_1;
    logic [31:0] in_data_2;
    logic        in_ready;
    logic        out_valid_1;
    logic        out_valid_2;
    logic [31:0] out_pc_1;
    logic [31:0] out_pc_2;
    logic [31:0] out_inst_1;
    logic [31:0] out_inst_2;
    logic [1:0]  deq_num;
    logic [3:0]  count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_full_cycles;
    logic [31:0] perf_empty_cycles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    inst_fetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .flush       (flush),
        .in_ok_1     (in_ok_1),
        .in_ok_2     (in_ok_2),
        .in_pc       (in_pc),
        .in_data_1   (in_data_1),
        .in_data_2   (in_data_2),
        .in_ready    (in_ready),
        .out_valid_1 (out_valid_1),
        .out_valid_2 (out_valid_2),
        .out_pc_1    (out_pc_1),
        .out_pc_2    (out_pc_2),
        .out_inst_1  (out_inst_1),
        .out_inst_2  (out_inst_2),
        .deq_num     (deq_num),
        .count       (count)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_full_cycles  (perf_full_cycles),
        .perf_empty_cycles (perf_empty_cycles)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Fetch must never present an instruction while the queue reports not ready.
    always @(posedge aclk) begin
        if (aresetn === 1'b1 && in_ok_1 === 1'b1) begin
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL protocol: in_ok_1 with in_ready=%b (t=%0t)", in_ready, $time);
            end
        end
    end

    typedef struct {
        logic        flush;
        logic        ok1;
        logic        ok2;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [1:0]  deq;
        int          ecnt;
        logic [31:0] epc1;
        logic [31:0] ei1;
        logic [31:0] epc2;
        logic [31:0] ei2;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic fl, input logic o1, input logic o2, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [1:0] dq,
                       input int ecnt, input logic [31:0] epc1, input logic [31:0] ei1,
                       input logic [31:0] epc2, input logic [31:0] ei2);
        vec_t v;
        v.flush = fl; v.ok1 = o1; v.ok2 = o2; v.pc = pc; v.d1 = d1; v.d2 = d2; v.deq = dq;
        v.ecnt = ecnt; v.epc1 = epc1; v.ei1 = ei1; v.epc2 = epc2; v.ei2 = ei2;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        flush = 0; in_ok_1 = 0; in_ok_2 = 0; in_pc = '0;
        in_data_1 = '0; in_data_2 = '0; deq_num = 2'd0;
    endtask

    // Reference model: an ordered list of {pc,inst} entries.
    fq_entry_t mq[$];

    task automatic model_step(input logic fl, input logic o1, input logic o2, input logic [31:0] pc,
                              input logic [31:0] d1, input logic [31:0] d2, input logic [1:0] dq);
        int n;
        bit rdy;
        fq_entry_t e;
        rdy = (DEPTH - mq.size()) >= 2;
        if (fl) begin
            mq.delete();
        end else begin
            n = (dq == 2'd3) ? 2 : int'(dq);
            if (n > mq.size()) n = mq.size();
            repeat (n) void'(mq.pop_front());
            if (o1 && rdy) begin
                e.pc = pc; e.inst = d1; mq.push_back(e);
                if (o2) begin
                    e.pc = pc + 32'd4; e.inst = d2; mq.push_back(e);
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".count"}, {28'd0, count}, sz);
        chk({tag, ".v1"}, {31'd0, out_valid_1}, {31'd0, sz >= 1});
        chk({tag, ".v2"}, {31'd0, out_valid_2}, {31'd0, sz >= 2});
        chk({tag, ".ready"}, {31'd0, in_ready}, {31'd0, (DEPTH - sz) >= 2});
        if (sz >= 1) begin
            chk({tag, ".pc1"}, out_pc_1, mq[0].pc);
            chk({tag, ".inst1"}, out_inst_1, mq[0].inst);
        end
        if (sz >= 2) begin
            chk({tag, ".pc2"}, out_pc_2, mq[1].pc);
            chk({tag, ".inst2"}, out_inst_2, mq[1].inst);
        end
    endtask

    initial begin
        idle_inputs();
        aresetn = 1'b0;
        in_ok_1 = 1'b1;
        in_ok_2 = 1'b1;
        in_pc   = 32'h1234_0000;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        idle_inputs();
        #1;
        chk("rst.count", {28'd0, count}, 32'd0);
        chk("rst.ready", {31'd0, in_ready}, 32'd1);
        chk("rst.v1", {31'd0, out_valid_1}, 32'd0);
        chk("rst.v2", {31'd0, out_valid_2}, 32'd0);

        // flush ok1 ok2 pc d1 d2 deq | count pc1 inst1 pc2 inst2
        add(0,1,1,32'hBFC0_0000,32'h11,32'h22,0, 2, 32'hBFC0_0000,32'h11,32'hBFC0_0004,32'h22);
        add(0,1,1,32'hBFC0_0008,32'h33,32'h44,0, 4, 32'hBFC0_0000,32'h11,32'hBFC0_0004,32'h22);
        add(0,1,1,32'hBFC0_0010,32'h55,32'h66,0, 6, 32'hBFC0_0000,32'h11,32'hBFC0_0004,32'h22);
        add(0,1,0,32'hBFC0_0018,32'h77,32'h00,0, 7, 32'hBFC0_0000,32'h11,32'hBFC0_0004,32'h22);
        add(0,0,0,32'h0,32'h0,32'h0,1,            6, 32'hBFC0_0004,32'h22,32'hBFC0_0008,32'h33);
        add(0,1,1,32'hBFC0_001C,32'h88,32'h99,0, 8, 32'hBFC0_0004,32'h22,32'hBFC0_0008,32'h33);
        add(0,0,0,32'h0,32'h0,32'h0,2,            6, 32'hBFC0_000C,32'h44,32'hBFC0_0010,32'h55);
        add(0,0,0,32'h0,32'h0,32'h0,3,            4, 32'hBFC0_0014,32'h66,32'hBFC0_0018,32'h77);
        add(0,1,1,32'hBFC0_0024,32'hAA,32'hBB,2, 4, 32'hBFC0_001C,32'h88,32'hBFC0_0020,32'h99);
        add(0,0,0,32'h0,32'h0,32'h0,2,            2, 32'hBFC0_0024,32'hAA,32'hBFC0_0028,32'hBB);
        add(0,0,0,32'h0,32'h0,32'h0,1,            1, 32'hBFC0_0028,32'hBB,32'h0,32'h0);
        add(0,1,1,32'hBFC0_002C,32'hCC,32'hDD,2, 2, 32'hBFC0_002C,32'hCC,32'hBFC0_0030,32'hDD);
        add(0,1,1,32'hBFC0_0034,32'hEE,32'hEF,2, 2, 32'hBFC0_0034,32'hEE,32'hBFC0_0038,32'hEF);
        add(0,0,0,32'h0,32'h0,32'h0,2,            0, 32'h0,32'h0,32'h0,32'h0);
        add(0,1,1,32'hFFFF_FFFC,32'hE1,32'hE2,0, 2, 32'hFFFF_FFFC,32'hE1,32'h0000_0000,32'hE2);
        add(0,1,1,32'h0000_0100,32'hF1,32'hF2,0, 4, 32'hFFFF_FFFC,32'hE1,32'h0000_0000,32'hE2);
        add(0,1,0,32'h0000_0108,32'hF3,32'h00,0, 5, 32'hFFFF_FFFC,32'hE1,32'h0000_0000,32'hE2);
        add(1,1,1,32'h0000_0200,32'hD1,32'hD2,2, 0, 32'h0,32'h0,32'h0,32'h0);
        add(0,0,0,32'h0,32'h0,32'h0,2,            0, 32'h0,32'h0,32'h0,32'h0);
        add(0,1,0,32'h0000_0300,32'hA5,32'h00,0, 1, 32'h0000_0300,32'hA5,32'h0,32'h0);

        foreach (vq[i]) begin
            flush = vq[i].flush; in_ok_1 = vq[i].ok1; in_ok_2 = vq[i].ok2; in_pc = vq[i].pc;
            in_data_1 = vq[i].d1; in_data_2 = vq[i].d2; deq_num = vq[i].deq;
            model_step(vq[i].flush, vq[i].ok1, vq[i].ok2, vq[i].pc, vq[i].d1, vq[i].d2, vq[i].deq);
            @(posedge aclk);
            #1;
            idle_inputs();
            chk($sformatf("vec%0d.count", i), {28'd0, count}, vq[i].ecnt);
            chk($sformatf("vec%0d.v1", i), {31'd0, out_valid_1}, {31'd0, vq[i].ecnt >= 1});
            chk($sformatf("vec%0d.v2", i), {31'd0, out_valid_2}, {31'd0, vq[i].ecnt >= 2});
            chk($sformatf("vec%0d.ready", i), {31'd0, in_ready}, {31'd0, (DEPTH - vq[i].ecnt) >= 2});
            if (vq[i].ecnt >= 1) begin
                chk($sformatf("vec%0d.pc1", i), out_pc_1, vq[i].epc1);
                chk($sformatf("vec%0d.inst1", i), out_inst_1, vq[i].ei1);
            end
            if (vq[i].ecnt >= 2) begin
                chk($sformatf("vec%0d.pc2", i), out_pc_2, vq[i].epc2);
                chk($sformatf("vec%0d.inst2", i), out_inst_2, vq[i].ei2);
            end
        end

        // Random traffic; the model and DUT must agree every cycle.
        for (int c = 0; c < 800; c++) begin
            logic        fl, o1, o2;
            logic [31:0] pc;
            logic [1:0]  dq;
            fl = ($urandom_range(0, 99) < 4);
            o1 = ((DEPTH - mq.size()) >= 2) && ($urandom_range(0, 99) < 65);
            o2 = ($urandom_range(0, 1) == 1);
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            dq = 2'($urandom_range(0, 3));
            flush = fl; in_ok_1 = o1; in_ok_2 = o2; in_pc = pc;
            in_data_1 = $urandom(); in_data_2 = $urandom(); deq_num = dq;
            model_step(fl, o1, o2, pc, in_data_1, in_data_2, dq);
            @(posedge aclk);
            #1;
            idle_inputs();
            check_model("rnd");
        end

        // Fill up, then reset asynchronously in the middle of a cycle with traffic pending.
        for (int k = 0; k < 3; k++) begin
            in_ok_1 = ((DEPTH - mq.size()) >= 2); in_ok_2 = 1; in_pc = 32'h8000_0000 + 32'(k * 8);
            in_data_1 = 32'hC0 + 32'(k); in_data_2 = 32'hD0 + 32'(k);
            model_step(0, in_ok_1, 1, in_pc, in_data_1, in_data_2, 0);
            @(posedge aclk);
            #1;
            idle_inputs();
        end
        check_model("prerst");
        in_ok_1 = 1; in_ok_2 = 1; deq_num = 2'd2;
        #2;
        aresetn = 1'b0;
        #1;
        chk("midrst.count", {28'd0, count}, 32'd0);
        chk("midrst.v1", {31'd0, out_valid_1}, 32'd0);
        chk("midrst.ready", {31'd0, in_ready}, 32'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        idle_inputs();
        mq.delete();
        check_model("postrst");
        in_ok_1 = 1; in_ok_2 = 0; in_pc = 32'h0000_4000; in_data_1 = 32'h5A5A_5A5A;
        model_step(0, 1, 0, in_pc, in_data_1, 32'h0, 0);
        @(posedge aclk);
        #1;
        idle_inputs();
        check_model("postrst_enq");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
